dbg_halt_ctrl: RTL and testbench

Debug halt/resume controller for the pipelined RV32 core. It receives halt, resume and single-step requests from the external debugger and drives the core's freeze and redirect controls. It drains the in-flight instructions before reporting "halted", and records the resume PC (dpc). It sits beside the forwarding/stall unit. Its `dbg_stall` is ORed with the hazard stall at the fetch/PC register, and its redirect port shares the PC mux with the branch path.

---
 rtl/dbg_pkg.sv | 22 ++
 rtl/dbg_drain_cnt.sv | 34 +++
 rtl/dbg_halt_ctrl.sv | 127 ++++++++++++
 tb/tb_dbg_halt_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared debug-controller types: FSM state and halt cause encodings, default PC width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dbg_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    DRAIN      = 3'd1,
    HALTED     = 3'd2,
    RESUME     = 3'd3,
    STEP_ISSUE = 3'd4
  } dbg_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    HALTREQ = 2'd1,
    STEP    = 2'd2
  } dbg_cause_t;

endpackage

// File: rtl/dbg_drain_cnt.sv
// Loadable down-counter that tracks how many pipeline stages are still draining.
// Latency: load/decrement visible the cycle after the edge; zero flag is registered-state decode.
// Backpressure: hold (load-use stall) freezes the count so stalled cycles do not count as drained.
module dbg_drain_cnt #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  input  logic hold,
  output logic zero
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  // The zero-count cycle is itself the last drain cycle, hence the minus one.
  localparam logic [CW-1:0] LOAD_VAL = CW'(DRAIN_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Load wins; otherwise count down only on cycles where the pipeline advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && !hold && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dbg_halt_ctrl.sv
// Debug halt/resume/step controller: freezes fetch, drains the pipe, captures dpc and cause.
// Latency: dbg_stall 1 cycle after halt_req; halted after 1+DRAIN_CYCLES+hazard cycles.
// Backpressure: hz_stall holds the drain count and holds STEP_ISSUE until the step instruction enters.
module dbg_halt_ctrl #(
  parameter int XLEN         = dbg_pkg::XLEN,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt_req,
  input  logic            resume_req,
  input  logic            step_req,
  input  logic            hz_stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] pc_f,
  output logic            dbg_stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            halted,
  output logic            halt_ack,
  output logic            resume_ack,
  output logic [XLEN-1:0] dpc,
  output logic [1:0]      cause
);

  import dbg_pkg::*;

  localparam logic [2:0] S_RUN    = RUN;
  localparam logic [2:0] S_DRAIN  = DRAIN;
  localparam logic [2:0] S_HALTED = HALTED;
  localparam logic [2:0] S_RESUME = RESUME;
  localparam logic [2:0] S_STEP   = STEP_ISSUE;

  logic [2:0]      state_q;
  logic [2:0]      state_nxt;
  logic            step_first_q;
  logic            halt_ack_q;
  logic [XLEN-1:0] dpc_q;
  logic [1:0]      cause_q;
  logic            cnt_load;
  logic            cnt_zero;
  logic            halt_take;
  logic            step_go;

  // A halt is only accepted in RUN; a step leaves STEP_ISSUE once fetch actually advances.
  assign halt_take = (state_q == S_RUN) && halt_req;
  assign step_go   = (state_q == S_STEP) && !hz_stall;
  assign cnt_load  = halt_take || step_go;

  dbg_drain_cnt #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_drain_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .en   (state_q == S_DRAIN),
    .hold (hz_stall),
    .zero (cnt_zero)
  );

  // Next-state decode; requests outside their legal state simply fall through.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_RUN:    if (halt_req) state_nxt = S_DRAIN;
      S_DRAIN:  if (cnt_zero && !hz_stall) state_nxt = S_HALTED;
      S_HALTED: begin
        if (resume_req)    state_nxt = S_RESUME;
        else if (step_req) state_nxt = S_STEP;
      end
      S_RESUME: state_nxt = S_RUN;
      S_STEP:   if (!hz_stall) state_nxt = S_DRAIN;
      default:  state_nxt = S_RUN;
    endcase
  end

  // State plus the one-shot flags that mark the first cycle of HALTED and STEP_ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      halt_ack_q   <= 1'b0;
      step_first_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      halt_ack_q   <= (state_q == S_DRAIN) && (state_nxt == S_HALTED);
      step_first_q <= (state_q == S_HALTED) && (state_nxt == S_STEP);
    end
  end

  // Resume PC: fetch PC at halt, overridden by an older branch still draining, advanced past a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpc_q <= '0;
    end else if (halt_take) begin
      dpc_q <= pc_f;
    end else if ((state_q == S_DRAIN) && br_taken) begin
      dpc_q <= br_target;
    end else if (step_go) begin
      dpc_q <= dpc_q + XLEN'(4);
    end
  end

  // Halt cause as seen by the debugger; cleared when execution resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= NONE;
    end else if (halt_take) begin
      cause_q <= HALTREQ;
    end else if (step_go) begin
      cause_q <= STEP;
    end else if (state_q == S_RESUME) begin
      cause_q <= NONE;
    end
  end

  assign dbg_stall      = (state_q == S_DRAIN) || (state_q == S_HALTED);
  assign halted         = (state_q == S_HALTED);
  assign halt_ack       = halt_ack_q;
  assign resume_ack     = (state_q == S_RESUME);
  // Only the first STEP_ISSUE cycle redirects; repeats under hazard must not refetch.
  assign redirect_valid = (state_q == S_RESUME) || ((state_q == S_STEP) && step_first_q);
  assign redirect_pc    = dpc_q;
  assign dpc            = dpc_q;
  assign cause          = cause_q;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Bench for dbg_halt_ctrl: directed latency scenarios then randomized requests vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dbg_halt_ctrl;

  localparam int XLEN = 32;
  localparam int DC   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            halt_req, resume_req, step_req, hz_stall, br_taken;
  logic [XLEN-1:0] br_target, pc_f;
  logic            dbg_stall, redirect_valid, halted, halt_ack, resume_ack;
  logic [XLEN-1:0] redirect_pc, dpc;
  logic [1:0]      cause;

  always #5 clk = ~clk;

  dbg_halt_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .halt_req      (halt_req),
    .resume_req    (resume_req),
    .step_req      (step_req),
    .hz_stall      (hz_stall),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .pc_f          (pc_f),
    .dbg_stall     (dbg_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted),
    .halt_ack      (halt_ack),
    .resume_ack    (resume_ack),
    .dpc           (dpc),
    .cause         (cause)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 running, 1 draining, 2 halted, 3 resuming, 4 stepping.
  int              m_mode;
  int              m_left;      // advancing drain cycles still owed before halted
  bit              m_ack;       // first halted cycle
  bit              m_sfirst;    // first stepping cycle
  logic [XLEN-1:0] m_dpc;
  int              m_cause;

  // Observed outputs captured at the last compare point.
  logic            obs_stall, obs_halted, obs_hack, obs_rack, obs_rv;
  logic [XLEN-1:0] obs_rpc, obs_dpc;
  logic [1:0]      obs_cause;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_ack = 0; m_sfirst = 0; m_dpc = '0; m_cause = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_step();
    m_ack    = 0;
    m_sfirst = 0;
    case (m_mode)
      0: if (halt_req) begin
           m_mode = 1; m_dpc = pc_f; m_cause = 1; m_left = DC;
         end
      1: begin
           if (br_taken) m_dpc = br_target;
           if (!hz_stall) begin
             m_left = m_left - 1;
             if (m_left == 0) begin m_mode = 2; m_ack = 1; end
           end
         end
      2: if (resume_req) m_mode = 3;
         else if (step_req) begin m_mode = 4; m_sfirst = 1; end
      3: begin m_mode = 0; m_cause = 0; end
      default: if (!hz_stall) begin
           m_mode = 1; m_cause = 2; m_dpc = m_dpc + 32'd4; m_left = DC;
         end
    endcase
  endtask

  task automatic compare_all();
    chk("dbg_stall",      32'(dbg_stall),      32'(m_mode == 1 || m_mode == 2));
    chk("halted",         32'(halted),         32'(m_mode == 2));
    chk("halt_ack",       32'(halt_ack),       32'(m_ack));
    chk("resume_ack",     32'(resume_ack),     32'(m_mode == 3));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_mode == 3 || (m_mode == 4 && m_sfirst)));
    chk("redirect_pc",    redirect_pc,         m_dpc);
    chk("dpc",            dpc,                 m_dpc);
    chk("cause",          32'(cause),          32'(m_cause));
  endtask

  // One clock: apply inputs, compare on the falling edge, step model on the rising edge.
  task automatic cycle(input logic h, input logic r, input logic s, input logic hz,
                       input logic br, input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] pc);
    halt_req = h; resume_req = r; step_req = s; hz_stall = hz;
    br_taken = br; br_target = tgt; pc_f = pc;
    @(negedge clk);
    obs_stall = dbg_stall; obs_halted = halted; obs_hack = halt_ack; obs_rack = resume_ack;
    obs_rv = redirect_valid; obs_rpc = redirect_pc; obs_dpc = dpc; obs_cause = cause;
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input logic hz);
    cycle(1'b0, 1'b0, 1'b0, hz, 1'b0, '0, 32'h0000_0400);
  endtask

  task automatic do_reset();
    halt_req = 0; resume_req = 0; step_req = 0; hz_stall = 0; br_taken = 0;
    br_target = '0; pc_f = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Run idle cycles until halted is observed; returns cycle offset or -1 within a bound.
  task automatic wait_halted(input int start, output int at);
    at = -1;
    for (int k = start; k < start + 20 && at < 0; k++) begin
      idle(1'b0);
      if (obs_halted) at = k;
    end
  endtask

  initial begin
    int at;
    halt_req = 0; resume_req = 0; step_req = 0; hz_stall = 0; br_taken = 0;
    br_target = '0; pc_f = '0;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_stall",  32'(dbg_stall), 32'd0);
    chk("rst_halted", 32'(halted),    32'd0);
    chk("rst_rv",     32'(redirect_valid), 32'd0);
    chk("rst_dpc",    dpc,            32'd0);
    chk("rst_cause",  32'(cause),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Halt with no hazards: request sampled at cycle 0.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0000_0100);
    idle(1'b0);
    chk("halt_stall_c1", 32'(obs_stall), 32'd1);
    wait_halted(2, at);
    chk("halt_latency", 32'(at), 32'd4);
    chk("halt_ack_c4",  32'(obs_hack), 32'd1);
    chk("halt_dpc",     obs_dpc, 32'h0000_0100);
    chk("halt_cause",   32'(obs_cause), 32'd1);
    idle(1'b0);
    chk("halt_ack_once", 32'(obs_hack), 32'd0);

    // Back to RUN, then halt with two hazard cycles in DRAIN.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    idle(1'b0); idle(1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0000_0100);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    wait_halted(4, at);
    chk("hz_halt_latency", 32'(at), 32'd6);
    chk("hz_dpc", obs_dpc, 32'h0000_0100);

    // Branch in drain overrides dpc.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    idle(1'b0); idle(1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0000_0100);
    idle(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0);
    wait_halted(3, at);
    chk("br_dpc", obs_dpc, 32'h0000_0200);

    // Step from dpc 0x200.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h0);
    idle(1'b0);
    chk("step_rv",    32'(obs_rv),    32'd1);
    chk("step_rpc",   obs_rpc,        32'h0000_0200);
    chk("step_stall", 32'(obs_stall), 32'd0);
    wait_halted(1, at);
    chk("step_latency", 32'(at), 32'd4);
    chk("step_ack",   32'(obs_hack),  32'd1);
    chk("step_dpc",   obs_dpc,        32'h0000_0204);
    chk("step_cause", 32'(obs_cause), 32'd2);

    // Resume and step together: resume wins.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 32'h0);
    idle(1'b0);
    chk("both_rack", 32'(obs_rack), 32'd1);
    chk("both_rpc",  obs_rpc,       32'h0000_0204);
    idle(1'b0);
    chk("resume_run_stall", 32'(obs_stall), 32'd0);
    chk("resume_cause",     32'(obs_cause), 32'd0);

    // Resume in RUN is ignored.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    idle(1'b0);
    chk("run_resume_ignored", 32'(obs_rack), 32'd0);

    // Reset mid-drain.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0000_0300);
    idle(1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall",  32'(dbg_stall), 32'd0);
    chk("mid_rst_halted", 32'(halted),    32'd0);
    chk("mid_rst_dpc",    dpc,            32'd0);
    do_reset();

    // Randomized traffic against the model, including dpc wrap-around targets.
    for (int i = 0; i < 4000; i++) begin
      logic [XLEN-1:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 600) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, tgt, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
